sm2201_bus_initiator: RTL and testbench
=======================================

# sm2201_bus_initiator

Synthesizable initiator for the SM2201 ISA–CAMAC interface board's register-access protocol; it is the driving end of the `sel`/`a`/`w`/`rdy` handshake that `micro_program_automate` responds to. It accepts a request (2-bit register address plus read/write flag) on a valid/ready port, sequences `sel`, `a` and `w` with programmable setup and hold, waits for `rdy`, and reports completion or timeout. It replaces hand-written stimulus in board-level benches and serves as the host-side sequencer in the bring-up FPGA image.

## Interface
- `SETUP_CYCLES`, 2: cycles `a`/`w` are stable before `sel` falls; legal range 1..255.
- `HOLD_CYCLES`, 1: cycles `sel` stays low after `rdy` is seen high; legal range 0..255.
- `TIMEOUT_CYCLES`, 1024: watchdog limit per wait state; legal range 1..65535.

- `clk` input 1: system clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: initiator can accept a request.
- `req_addr` input 2: register address.
- `req_write` input 1: 1 = write cycle, 0 = read cycle.
- `a` output 2: address to the responder.
- `w` output 1: write flag to the responder.
- `sel` output 1: select, active-low.
- `rdy` input 1: responder ready, active-high.
- `busy` output 1: a transaction is in progress.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: one-cycle timeout pulse, coincident with `done`.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, RELEASE.
- Reset values: state IDLE, `sel`=1, `a`=0, `w`=0, `busy`=0, `done`=0, `err`=0, `req_ready`=0 while `reset` is high.
- IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, register `req_addr`→`a` and `req_write`→`w`, then enter SETUP.
- SETUP: `sel`=1 for exactly `SETUP_CYCLES` cycles, then enter STROBE.
- STROBE: `sel`=0. When `rdy` is sampled 1, enter HOLD; if `HOLD_CYCLES`=0, enter RELEASE directly.
- HOLD: `sel`=0 for `HOLD_CYCLES` cycles, then enter RELEASE.
- RELEASE: `sel`=1. When `rdy` is sampled 0, pulse `done` and enter IDLE.
- `a` and `w` stay constant from SETUP through RELEASE. In IDLE they retain their last values; they are not cleared.
- `busy`=1 in every state except IDLE.
- A 16-bit cycle counter is shared by SETUP, HOLD and the watchdog. It clears on every state entry and saturates at 65535.
- `req_*` inputs are ignored outside IDLE.

## Timing
- Request accepted at edge N. `a`/`w` are valid from N+1. `sel` falls at N+1+`SETUP_CYCLES`.
- `rdy` rising is sampled at edge M in STROBE. `sel` rises at M+1+`HOLD_CYCLES`.
- `rdy` low is sampled at edge K in RELEASE. `done` is high during cycle K+1, and `req_ready` is high in that same cycle.
- Back-to-back: a request may be accepted in the `done` cycle. There is no idle bubble.
- `rdy` already high on entry to STROBE counts immediately; STROBE then lasts one cycle.
- Reset mid-transaction: the next edge forces IDLE, and `sel` returns to 1 with no `done`.

## Configuration
- `SM2201_INITIATOR_TIMEOUT_EN` defined: the watchdog is active in STROBE and RELEASE.
  - When the counter reaches `TIMEOUT_CYCLES`, the next edge drives `sel`=1, enters IDLE and pulses `done`=1 and `err`=1 together.
- `SM2201_INITIATOR_TIMEOUT_EN` not defined: STROBE and RELEASE wait indefinitely, and `err` is tied to 0.

## Test plan
- Write, addr 2, `rdy` rises 5 cycles after `sel` falls and drops 3 cycles after `sel` rises:
  - `a`=2 and `w`=1 are stable throughout.
  - `sel` is low for 5+1+1 cycles.
  - A single `done` pulse occurs and `err`=0.
- Read, addr 1, `SETUP_CYCLES`=3: `sel` falls exactly 4 edges after acceptance, and `w`=0 throughout.
- Two queued requests (addr 0 write, addr 3 read): the second is accepted in the first `done` cycle, and no cycle has `busy`=0 between them.
- `rdy` held 0 with the macro defined and `TIMEOUT_CYCLES`=16:
  - `done`=`err`=1 occurs 17 edges after STROBE entry.
  - `sel`=1 follows.
  - Without the macro, `sel` stays 0 for 1000 cycles.
- `rdy` stuck at 1 after the strobe, macro defined: the RELEASE timeout fires and `err`=1.
- `reset` asserted 2 cycles into STROBE:
  - The next edge gives `sel`=1, `busy`=0, `done`=0.
  - After release, a new request completes normally.

Source files
------------

// File: rtl/sm2201_bus_initiator.sv
// sm2201_bus_initiator: sel/a/w/rdy register-access initiator; watchdog enabled by SM2201_INITIATOR_TIMEOUT_EN
module sm2201_bus_initiator #(
    parameter int SETUP_CYCLES   = 2,
    parameter int HOLD_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [1:0] req_addr_i,
    input  logic       req_write_i,
    output logic [1:0] a_o,
    output logic       w_o,
    output logic       sel_o,
    input  logic       rdy_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);
`ifdef SM2201_INITIATOR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RELEASE} state_t;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  a_q, a_d;
    logic        w_q, w_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        expired;
    assign expired = TO_EN && (cnt_q >= 16'(TIMEOUT_CYCLES));
    assign a_o     = a_q;
    assign w_o     = w_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    // next state, captured request, completion pulses and combinational handshake outputs
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        w_d         = w_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        req_ready_o = (state_q == IDLE) && !reset_i;
        busy_o      = state_q != IDLE;
        sel_o       = !((state_q == STROBE) || (state_q == HOLD));
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d = SETUP;
                    a_d     = req_addr_i;
                    w_d     = req_write_i;
                end
            end
            SETUP: state_d = (cnt_q == 16'(SETUP_CYCLES - 1)) ? STROBE : SETUP;
            STROBE: begin
                if (expired) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (rdy_i) begin
                    state_d = (HOLD_CYCLES == 0) ? RELEASE : HOLD;
                end
            end
            HOLD: state_d = (cnt_q == 16'(HOLD_CYCLES - 1)) ? RELEASE : HOLD;
            RELEASE: begin
                if (expired || !rdy_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = expired;
                end
            end
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q) ? 16'd0 : (&cnt_q ? cnt_q : cnt_q + 16'd1);
    end
    // state, shared saturating counter and output registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            w_q     <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            w_q     <= w_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_sm2201_bus_initiator.sv
// tb_sm2201_bus_initiator: vector table plus directed multi-cycle sequences for the bus initiator
module tb_sm2201_bus_initiator;
    logic       clk = 1'b0;
    logic       reset, req_valid, req_ready, req_write, w, sel, rdy, busy, done, err;
    logic [1:0] req_addr, a;
    int         checks = 0, failures = 0, k, idle;
    logic       bad, e;
    typedef struct {
        logic       rst, vld;
        logic [1:0] addr;
        logic       wr, rdy;
        logic [7:0] exp;
    } vec_t;
    vec_t vec[18];

    sm2201_bus_initiator #(.SETUP_CYCLES(3), .HOLD_CYCLES(1), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_write_i(req_write), .a_o(a), .w_o(w), .sel_o(sel),
        .rdy_i(rdy), .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic rs, input logic v, input logic [1:0] ad,
                        input logic wr, input logic ry, input logic [7:0] ex);
        vec[i] = '{rs, v, ad, wr, ry, ex};
    endtask

    // simple responder: rdy follows inverted sel until done appears
    task automatic run_until_done(input string name, output logic er);
        int n = 0;
        while (done !== 1'b1 && n < 60) begin
            rdy = !sel;
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, done, 1);
        er  = err;
        rdy = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        reset = 1; req_valid = 0; req_addr = 0; req_write = 0; rdy = 0;
        repeat (2) @(posedge clk);
        // exp = {sel, busy, done, err, req_ready, a[1:0], w}
        setv(0, 1, 0, 0, 0, 0, 8'b1_0_0_0_0_00_0);
        setv(1, 0, 1, 2, 1, 0, 8'b1_0_0_0_1_00_0);
        setv(2, 0, 0, 0, 0, 0, 8'b1_1_0_0_0_10_1);
        setv(3, 0, 0, 0, 0, 0, 8'b1_1_0_0_0_10_1);
        setv(4, 0, 0, 0, 0, 0, 8'b1_1_0_0_0_10_1);
        for (int i = 5; i < 10; i++) setv(i, 0, 0, 0, 0, 0, 8'b0_1_0_0_0_10_1);
        setv(10, 0, 0, 0, 0, 1, 8'b0_1_0_0_0_10_1);
        setv(11, 0, 0, 0, 0, 1, 8'b0_1_0_0_0_10_1);
        for (int i = 12; i < 15; i++) setv(i, 0, 0, 0, 0, 1, 8'b1_1_0_0_0_10_1);
        setv(15, 0, 0, 0, 0, 0, 8'b1_1_0_0_0_10_1);
        setv(16, 0, 0, 0, 0, 0, 8'b1_0_1_0_1_10_1);
        setv(17, 0, 0, 0, 0, 0, 8'b1_0_0_0_1_10_1);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            reset = vec[i].rst; req_valid = vec[i].vld; req_addr = vec[i].addr;
            req_write = vec[i].wr; rdy = vec[i].rdy;
            #1;
            chk($sformatf("vec%0d", i), {sel, busy, done, err, req_ready, a, w}, vec[i].exp);
        end

        // read addr 1: sel falls 4 edges after acceptance, w low throughout
        @(negedge clk); req_valid = 1; req_addr = 1; req_write = 0; rdy = 0;
        #1 chk("rd_ready", req_ready, 1);
        @(negedge clk); req_valid = 0; k = 1; bad = 0;
        while (sel && k < 20) begin
            if (w !== 1'b0 || a !== 2'd1) bad = 1;
            @(negedge clk);
            k++;
        end
        chk("rd_sel_fall", k, 4);
        chk("rd_w_low", bad, 0);

`ifdef SM2201_INITIATOR_TIMEOUT_EN
        k = 0;
        while (done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("strobe_to_edges", k, 17);
        chk("strobe_to_err", err, 1);
        chk("strobe_to_sel", sel, 1);
        @(negedge clk);
        chk("strobe_to_pulse", {done, err}, 0);
        req_valid = 1; req_addr = 2; req_write = 1; rdy = 1;
        @(negedge clk); req_valid = 0; k = 0;
        while (done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("release_to_edges", k, 22);
        chk("release_to_err", err, 1);
        rdy = 0;
`else
        bad = 0;
        repeat (1000) begin
            if (sel !== 1'b0 || done !== 1'b0) bad = 1;
            @(negedge clk);
        end
        chk("stall_sel_low", bad, 0);
        run_until_done("stall", e);
        chk("stall_err", e, 0);
        chk("stall_aw", {a, w}, 3'b010);
`endif

        // back-to-back: second request accepted in the first done cycle
        @(negedge clk); req_valid = 1; req_addr = 0; req_write = 1; rdy = 0;
        #1 chk("b2b_ready", req_ready, 1);
        @(negedge clk); idle = 0; bad = 0; k = 0;
        while (done !== 1'b1 && k < 60) begin
            if (!busy) idle++;
            if (a !== 2'd0 || w !== 1'b1) bad = 1;
            rdy = !sel;
            @(negedge clk);
            k++;
        end
        chk("b2b_done1", done, 1);
        chk("b2b_done_ready", req_ready, 1);
        chk("b2b_gap", idle, 0);
        chk("b2b_aw1", bad, 0);
        req_addr = 3; req_write = 0;
        @(negedge clk); req_valid = 0;
        chk("b2b_busy2", busy, 1);
        chk("b2b_aw2", {a, w}, 3'b110);
        run_until_done("b2b2", e);
        chk("b2b2_err", e, 0);

        // reset two cycles into STROBE
        @(negedge clk); req_valid = 1; req_addr = 2; req_write = 1; rdy = 0;
        @(negedge clk); req_valid = 0; k = 0;
        while (sel && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk); reset = 1;
        #1 chk("rst_ready", req_ready, 0);
        @(negedge clk);
        chk("rst_outputs", {sel, busy, done, a}, 5'b10000);
        reset = 0;
        @(negedge clk); req_valid = 1; req_addr = 3; req_write = 1;
        @(negedge clk); req_valid = 0;
        run_until_done("post_rst", e);
        chk("post_rst_err", e, 0);
        chk("post_rst_aw", {a, w}, 3'b111);
        @(negedge clk);
        chk("post_rst_pulse", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
